// File: rtl/ofm_collector_writer_if.sv
// OFM collector/writer bus bundle: the PE-array capture side, the BRAM write
// port and the run control/status signals. The master drives start, base_addr,
// valid, ofm_bus and wr_ready. The slave (the collector) drives everything else.
interface ofm_collector_writer_if #(
    parameter int NUM_PE = 16,
    parameter int ADDR_W = 20
);
    logic                  start;
    logic [ADDR_W-1:0]     base_addr;
    logic [NUM_PE-1:0]     valid;
    logic [NUM_PE*8-1:0]   ofm_bus;
    logic                  wr_ready;
    logic                  we_OFM;
    logic [ADDR_W-1:0]     addr_OFM;
    logic [31:0]           data_out_OFM;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic                  err_partial;
    logic [15:0]           pixel_count;

    modport master (
        output start, base_addr, valid, ofm_bus, wr_ready,
        input  we_OFM, addr_OFM, data_out_OFM, busy, done, overflow,
               err_partial, pixel_count
    );

    modport slave (
        input  start, base_addr, valid, ofm_bus, wr_ready,
        output we_OFM, addr_OFM, data_out_OFM, busy, done, overflow,
               err_partial, pixel_count
    );
endinterface

// File: rtl/ofm_collector_writer.sv
// OFM collector/writer: the consumer end of the conv engine's OFM interface.
// When all PE valid bits are high, the block captures one pixel (one byte per PE)
// into a small pixel FIFO. It then writes each pixel to the OFM BRAM as
// NUM_PE/4 big-endian 32-bit words at base_addr + running word index.
// The serializer works on the FIFO head in place. The head entry is freed only
// when its last word transfers. While the BRAM stalls, the pixel being written
// therefore still occupies a FIFO slot.
// Optional build macro OFM_RELU_EN: each captured byte is treated as signed and
// clamped to zero when negative, before it is written into the FIFO.
// NUM_PE must be a multiple of 4. FIFO_DEPTH must be a power of 2 and >= 2.
module ofm_collector_writer #(
    parameter int NUM_PE     = 16,
    parameter int NUM_PIXELS = 3136,
    parameter int ADDR_W     = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    ofm_collector_writer_if.slave ofm_if
);
    localparam int WORDS = NUM_PE / 4;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int PIX_W = NUM_PE * 8;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);
    localparam logic [15:0]      LAST_PIXEL = 16'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    // Run control and status.
    logic [ADDR_W-1:0]   r_base;
    logic [15:0]         r_pixel_count;
    logic                r_overflow;
    logic                r_err_partial;

    // Pixel FIFO.
    logic [PIX_W-1:0]    r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_fifo_count;

    // Serializer.
    logic                r_ser_valid;
    logic [IDX_W-1:0]    r_word_idx;
    logic [ADDR_W-1:0]   r_wr_idx;

    logic                w_all_valid;
    logic                w_any_valid;
    logic                w_in_run;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_word_xfer;
    logic                w_pop;
    logic                w_capture_try;
    logic                w_push;
    logic                w_drop;
    logic                w_partial;
    logic                w_drain_done;
    logic [PIX_W-1:0]    w_pixel_in;
    logic [PIX_W-1:0]    w_head;
    logic [31:0]         w_word;

    assign w_all_valid  = &ofm_if.valid;
    assign w_any_valid  = |ofm_if.valid;
    assign w_in_run     = (r_state == S_RUN);
    assign w_fifo_full  = (r_fifo_count == FULL_CNT);
    assign w_fifo_empty = (r_fifo_count == '0);

    // The head entry is released only when its final word is accepted by the BRAM.
    assign w_word_xfer  = r_ser_valid & ofm_if.wr_ready;
    assign w_pop        = w_word_xfer & (r_word_idx == LAST_IDX);

    // start takes priority over any capture on the same edge. A pop frees a slot in
    // time for a simultaneous push.
    assign w_capture_try = w_in_run & w_all_valid & ~ofm_if.start;
    assign w_push        = w_capture_try & (~w_fifo_full | w_pop);
    assign w_drop        = w_capture_try & w_fifo_full & ~w_pop;
    assign w_partial     = w_in_run & w_any_valid & ~w_all_valid & ~ofm_if.start;

    // The drain is complete once nothing is queued. The transfer of the final word
    // of the last queued pixel also completes it, so done rises on that same edge.
    assign w_drain_done = (w_fifo_empty & ~r_ser_valid) | ((r_fifo_count == ONE_CNT) & w_pop);

    // Optional ReLU clamp applied to the incoming pixel before it is queued.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it
        // unassigned and infer a latch.
        w_pixel_in = ofm_if.ofm_bus;
`ifdef OFM_RELU_EN
        for (int k = 0; k < NUM_PE; k++) begin
            if (w_pixel_in[8*k+7]) begin
                w_pixel_in[8*k +: 8] = 8'h00;
            end
        end
`endif
    end

    // Select word r_word_idx of the FIFO head. Lower byte indices go to higher bit positions.
    always_comb begin
        w_head = r_fifo_mem[r_rd_ptr];
        w_word = '0;
        for (int b = 0; b < 4; b++) begin
            w_word[31-8*b -: 8] = w_head[32*int'(r_word_idx) + 8*b +: 8];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start always (re)arms a run; RUN and DRAIN advance on progress.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (ofm_if.start) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (ofm_if.start) begin
                    w_state_next = S_RUN;
                end else if (w_push && (r_pixel_count == LAST_PIXEL)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ofm_if.start) begin
                    w_state_next = S_RUN;
                end else if (w_drain_done) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (ofm_if.start) w_state_next = S_RUN;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Run bookkeeping: latch base, count captured pixels, hold sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base        <= '0;
            r_pixel_count <= '0;
            r_overflow    <= 1'b0;
            r_err_partial <= 1'b0;
        end else if (ofm_if.start) begin
            r_base        <= ofm_if.base_addr;
            r_pixel_count <= '0;
            r_overflow    <= 1'b0;
            r_err_partial <= 1'b0;
        end else begin
            if (w_push)    r_pixel_count <= r_pixel_count + 16'd1;
            if (w_drop)    r_overflow    <= 1'b1;
            if (w_partial) r_err_partial <= 1'b1;
        end
    end

    // FIFO pointers and occupancy. start flushes the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else if (ofm_if.start) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop) begin
                r_fifo_count <= r_fifo_count + ONE_CNT;
            end else if (w_pop && !w_push) begin
                r_fifo_count <= r_fifo_count - ONE_CNT;
            end
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        // NOTE: the pixel storage has no reset. The pointers and the occupancy count
        // define which entries are meaningful, and stale contents never reach an output.
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= w_pixel_in;
        end
    end

    // Serializer: walk the head pixel one word per accepted transfer. Rearm from the
    // queue without a gap when more pixels are already waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ser_valid <= 1'b0;
            r_word_idx  <= '0;
            r_wr_idx    <= '0;
        end else if (ofm_if.start) begin
            r_ser_valid <= 1'b0;
            r_word_idx  <= '0;
            r_wr_idx    <= '0;
        end else if (w_word_xfer) begin
            r_wr_idx <= r_wr_idx + ADDR_W'(1);
            if (r_word_idx == LAST_IDX) begin
                r_word_idx  <= '0;
                r_ser_valid <= (r_fifo_count > ONE_CNT);
            end else begin
                r_word_idx  <= r_word_idx + IDX_W'(1);
            end
        end else if (!r_ser_valid && !w_fifo_empty && (w_in_run || r_state == S_DRAIN)) begin
            r_ser_valid <= 1'b1;
            r_word_idx  <= '0;
        end
    end

    assign ofm_if.we_OFM       = r_ser_valid;
    assign ofm_if.addr_OFM     = r_base + r_wr_idx;
    assign ofm_if.data_out_OFM = r_ser_valid ? w_word : 32'h0;
    assign ofm_if.busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign ofm_if.done         = (r_state == S_DONE);
    assign ofm_if.overflow     = r_overflow;
    assign ofm_if.err_partial  = r_err_partial;
    assign ofm_if.pixel_count  = r_pixel_count;

endmodule

// File: doc/ofm_collector_writer.md
Name: ofm_collector_writer

Overview:
Consumer end of the conv engine's OFM interface; takes over the pixel-capture job the bench currently does.
- Captures one OFM pixel (one byte per PE) whenever all PE valid bits are high.
- Buffers captured pixels in a small FIFO, packs them into 32-bit words and writes them into the OFM BRAM using the same we/addr/data convention as the IFM/weight load path.
- Sits between the PE array outputs and the OFM buffer; signals done after a programmed number of pixels.

Parameters:
NUM_PE, 16, number of PEs (bytes per pixel); must be a multiple of 4
NUM_PIXELS, 3136, pixels per layer run (56x56)
ADDR_W, 20, OFM BRAM word-address width
FIFO_DEPTH, 4, pixel FIFO entries; power of 2

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; arms a run and latches base_addr
base_addr  in  ADDR_W  word address of the first write
valid  in  NUM_PE  per-PE OFM valid
ofm_bus  in  NUM_PE*8  PE k byte at [8k+7:8k]
wr_ready  in  1  BRAM side accepts the current write
we_OFM  out  1  write strobe
addr_OFM  out  ADDR_W  write word address
data_out_OFM  out  32  packed write data
busy  out  1  high in RUN or DRAIN
done  out  1  high in DONE
overflow  out  1  sticky: a pixel was dropped because the FIFO was full
err_partial  out  1  sticky: valid was nonzero but not all ones
pixel_count  out  16  pixels captured this run

Behaviour:
- Reset: every output is 0, FIFO is empty, state is IDLE. Applies asynchronously at any time, including mid-serialization.
- States:
  - IDLE: start -> RUN; latch base_addr; clear counters, sticky flags and FIFO.
  - RUN: capture pixels. When pixel_count reaches NUM_PIXELS -> DRAIN.
  - DRAIN: no further capture. When the FIFO is empty and the serializer is idle -> DONE.
  - DONE: done=1, held until start, which behaves as in IDLE.
  - start while in RUN or DRAIN: flush FIFO and serializer, restart RUN with the new base_addr.
- Capture rule (RUN only):
  - A pixel is captured on a clk edge where valid equals all ones.
  - valid nonzero but not all ones: set err_partial, no capture.
  - valid in IDLE, DRAIN or DONE: ignored.
- FIFO full on a capture edge: drop the pixel, set overflow; pixel_count does not increment. A capture and a pop in the same cycle are allowed, so a full FIFO with a simultaneous pop accepts the new pixel.
- Serializer:
  - Pops the FIFO head and emits NUM_PE/4 words.
  - Word j = {byte[4j], byte[4j+1], byte[4j+2], byte[4j+3]}, MSB-first, matching the IFM load packing.
  - addr_OFM = base + wr_idx, where wr_idx counts words written this run (ADDR_W-bit, wraps modulo 2^ADDR_W).
- Handshake:
  - A word transfers on an edge where we_OFM & wr_ready.
  - While wr_ready=0, we_OFM, addr_OFM and data_out_OFM hold stable.
  - we_OFM never deasserts without a transfer, except on reset or start.
- Latency and throughput:
  - Capture at edge N -> first word valid on outputs after edge N+1.
  - With wr_ready=1, the NUM_PE/4 words appear on consecutive cycles.
  - Back-to-back pixels are sustained at 1 pixel per NUM_PE/4 cycles; this is well within the 36-cycle PE cadence.

Optional Feature:
OFM_RELU_EN
- Defined: each byte is treated as signed and clamped to 0 if negative, before FIFO write.
- Undefined: bytes are passed unchanged.
- Packing, addressing and timing are identical in both cases.

Test Plan:
- Single pixel, ofm_bus bytes 0x00..0x0F, base_addr=0x100, wr_ready=1 -> writes 0x00010203@0x100, 0x04050607@0x101, 0x08090A0B@0x102, 0x0C0D0E0F@0x103 on 4 consecutive cycles starting one cycle after capture; pixel_count=1.
- NUM_PIXELS=4, four pixels spaced 36 cycles, base 0 -> 16 writes to addresses 0..15; done rises after the last transfer; busy falls the same cycle; further valid pulses produce no writes.
- wr_ready=0 for 30 cycles while 5 all-ones valid pulses arrive 2 cycles apart -> overflow=1, pixel_count=4; after wr_ready=1, exactly 16 words are written with the data of pixels 1-4; outputs are stable throughout the stall.
- valid=16'h7FFF for one cycle -> err_partial=1, no write, pixel_count=0.
- Reset asserted after the 2nd word of a pixel -> we_OFM=0 asynchronously, all outputs 0, IDLE; a following start plus one pixel writes from the new base_addr.
- Bytes 0x80, 0xFF, 0x7F, 0x01 -> packed word 0x0000_7F01 with OFM_RELU_EN; 0x80FF_7F01 without.
